// File: rtl/alu_issue_ctrl.sv
// Issue controller for the ALU operand/function interface.
// Takes one instruction per handshake, reads operands from an internal
// register file, holds them for the ALU's registered latency, then writes
// the result back and reports result and flag.
module alu_issue_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int IMM_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_flag,
    output logic [31:0] result,
    output logic [1:0]  flag_out,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    // state   | meaning
    // IDLE    | ready for an instruction
    // ISSUE   | operands/func presented, ALU samples them at the next edge
    // CAPTURE | alu_out valid, write back and load result at the next edge
    // FLAG    | alu_flag valid, load flag_out and pulse done at the next edge
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, FLAG} state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_RLAST = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_LI    = 4'hB;
    localparam logic [3:0] FUNC_ADD = 4'h1;

    state_t      state_q, state_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [3:0]  rd_q;
    logic        wb_q;

    logic [3:0]  op, rd, rs, rt;
    logic [31:0] imm_sext, rs_val, rt_val;
    logic [3:0]  dec_func;
    logic [31:0] dec_inp1, dec_inp2;
    logic        dec_legal, dec_wb;
    logic        ops_load, res_load, flag_load, illegal_d;

    assign op       = instr[31:28];
    assign rd       = instr[27:24];
    assign rs       = instr[23:20];
    assign rt       = instr[19:16];
    assign imm_sext = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

    // r0 is hard-wired to zero on every read port
    assign rs_val    = (rs == 4'd0) ? 32'd0 : regs_q[rs];
    assign rt_val    = (rt == 4'd0) ? 32'd0 : regs_q[rt];
    assign dbg_rdata = (dbg_raddr == 4'd0) ? 32'd0 : regs_q[dbg_raddr];

    assign instr_ready = (state_q == IDLE);

    // Opcode decode into function code, operand selection and writeback enable
    always_comb begin
        dec_func  = 4'h0;
        dec_inp1  = 32'd0;
        dec_inp2  = 32'd0;
        dec_legal = 1'b1;
        dec_wb    = 1'b0;
        if (op == OP_NOP) begin
            dec_wb = 1'b0;
        end else if (op <= OP_RLAST) begin
            dec_func = op;
            dec_inp1 = rs_val;
            dec_inp2 = rt_val;
            dec_wb   = 1'b1;
        end else if (op == OP_ADDI) begin
            dec_func = FUNC_ADD;
            dec_inp1 = rs_val;
            dec_inp2 = imm_sext;
            dec_wb   = 1'b1;
        end else if (op == OP_LI) begin
            dec_func = FUNC_ADD;
            dec_inp2 = imm_sext;
            dec_wb   = 1'b1;
        end else begin
            dec_legal = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and per-edge datapath strobes
    always_comb begin
        state_d   = state_q;
        ops_load  = 1'b0;
        res_load  = 1'b0;
        flag_load = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (dec_legal) begin
                        ops_load = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                res_load = 1'b1;
                state_d  = FLAG;
            end
            FLAG: begin
                flag_load = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/func latch, writeback, result/flag capture and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_inp1 <= 32'd0;
            alu_inp2 <= 32'd0;
            alu_func <= 4'h0;
            result   <= 32'd0;
            flag_out <= 2'b00;
            done     <= 1'b0;
            illegal  <= 1'b0;
            rd_q     <= 4'd0;
            wb_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
        end else begin
            done    <= flag_load;
            illegal <= illegal_d;
            if (ops_load) begin
                alu_func <= dec_func;
                alu_inp1 <= dec_inp1;
                alu_inp2 <= dec_inp2;
                rd_q     <= rd;
                wb_q     <= dec_wb && (rd != 4'd0);
            end
            if (res_load) begin
                result <= alu_out;
                if (wb_q) regs_q[rd_q] <= alu_out;
            end
            if (flag_load) begin
                flag_out <= alu_flag;
                alu_func <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural registered ALU
// and a scoreboard of expected writebacks.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] alu_inp1, alu_inp2;
    logic [3:0]  alu_func;
    logic [31:0] alu_out = 32'd0;
    logic [1:0]  alu_flag = 2'b00;
    logic [31:0] result;
    logic [1:0]  flag_out;
    logic        done, illegal;
    logic [3:0]  dbg_raddr = 4'd0;
    logic [31:0] dbg_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  flg;
        logic [3:0]  rd;
        logic [31:0] dbg;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_regs [16];
    logic [31:0] prog[$];

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_func(alu_func),
        .alu_out(alu_out), .alu_flag(alu_flag), .result(result), .flag_out(flag_out),
        .done(done), .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return ~a;
            4'h7: return a <<< b[4:0];
            4'h8: return $unsigned($signed(a) >>> b[4:0]);
            4'h9: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] flag_of(input logic [31:0] v);
        if (v == 32'd0) return 2'b11;
        if (v[31])      return 2'b01;
        return 2'b10;
    endfunction

    // Behavioural ALU: result one cycle after the operands, flag one cycle after that
    always @(posedge clk) begin
        alu_out  <= alu_fn(alu_func, alu_inp1, alu_inp2);
        alu_flag <= flag_of(alu_out);
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [15:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic push_expected(input logic [31:0] ins);
        exp_t        e;
        logic [3:0]  op, rd, rs, rt, f;
        logic [31:0] a, b, sx, ra, rb;
        op = ins[31:28]; rd = ins[27:24]; rs = ins[23:20]; rt = ins[19:16];
        sx = {{16{ins[15]}}, ins[15:0]};
        ra = (rs == 0) ? 32'd0 : ref_regs[rs];
        rb = (rt == 0) ? 32'd0 : ref_regs[rt];
        f = 4'h0; a = 32'd0; b = 32'd0;
        if (op >= 4'h1 && op <= 4'h9) begin f = op; a = ra; b = rb; end
        else if (op == 4'hA) begin f = 4'h1; a = ra; b = sx; end
        else if (op == 4'hB) begin f = 4'h1; a = 32'd0; b = sx; end
        e.res = alu_fn(f, a, b);
        e.flg = flag_of(e.res);
        e.rd  = rd;
        if (op != 4'h0 && rd != 4'd0) ref_regs[rd] = e.res;
        e.dbg = (rd == 4'd0) ? 32'd0 : ref_regs[rd];
        exp_q.push_back(e);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 16; i++) ref_regs[i] = 32'd0;
        exp_q.delete();
    endtask

    // Streams prog with instr_valid held high; checks each done against the scoreboard
    task automatic run_prog(input string name);
        int   acc_cyc[$];
        int   done_cyc[$];
        int   idx, ndone, cyc, n;
        exp_t e;
        idx = 0; ndone = 0; cyc = 0; n = prog.size();
        @(negedge clk);
        instr = prog[0];
        instr_valid = 1'b1;
        while (ndone < n && cyc < 16 * n + 8) begin
            if (done) begin
                e = exp_q.pop_front();
                done_cyc.push_back(cyc);
                checks++;
                if (result !== e.res) begin
                    failures++;
                    $display("FAIL %s result[%0d]: got %h expected %h", name, ndone, result, e.res);
                end
                checks++;
                if (flag_out !== e.flg) begin
                    failures++;
                    $display("FAIL %s flag_out[%0d]: got %b expected %b", name, ndone, flag_out, e.flg);
                end
                checks++;
                if (alu_func !== 4'h0) begin
                    failures++;
                    $display("FAIL %s alu_func_idle[%0d]: got %h expected 0", name, ndone, alu_func);
                end
                dbg_raddr = e.rd;
                #1;
                checks++;
                if (dbg_rdata !== e.dbg) begin
                    failures++;
                    $display("FAIL %s reg r%0d: got %h expected %h", name, e.rd, dbg_rdata, e.dbg);
                end
                ndone++;
            end
            if (instr_valid && instr_ready) begin
                push_expected(prog[idx]);
                acc_cyc.push_back(cyc);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < n) instr = prog[idx];
            else begin
                instr_valid = 1'b0;
                instr = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        instr_valid = 1'b0;
        checks++;
        if (ndone != n || acc_cyc.size() != n) begin
            failures++;
            $display("FAIL %s timeout: done=%0d accepts=%0d expected %0d", name, ndone, acc_cyc.size(), n);
            exp_q.delete();
        end else begin
            for (int k = 0; k < n; k++) begin
                checks++;
                if (done_cyc[k] - acc_cyc[k] != 4) begin
                    failures++;
                    $display("FAIL %s latency[%0d]: got %0d expected 4", name, k, done_cyc[k] - acc_cyc[k]);
                end
                if (k < n - 1) begin
                    checks++;
                    if (acc_cyc[k+1] != done_cyc[k]) begin
                        failures++;
                        $display("FAIL %s next_accept[%0d]: got cycle %0d expected %0d", name, k, acc_cyc[k+1], done_cyc[k]);
                    end
                end
            end
        end
        prog.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_ref();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: done=%b illegal=%b expected 0 0", done, illegal);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", instr_ready);
        end
        checks++;
        if (alu_func !== 4'h0 || result !== 32'd0 || flag_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: func=%h result=%h flag=%b expected 0 0 00", alu_func, result, flag_out);
        end
        checks++;
        if (done !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_pulses: done=%b illegal=%b expected 0 0", done, illegal);
        end
        for (int i = 0; i < 16; i++) begin
            dbg_raddr = 4'(i);
            #1;
            checks++;
            if (dbg_rdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg r%0d: got %h expected 0", i, dbg_rdata);
            end
        end
    endtask

    task automatic test_li();
        logic [31:0] want [3];
        prog.push_back(mk(4'hB, 4'd1, 4'd0, 4'd0, 16'h0005));
        prog.push_back(mk(4'hB, 4'd2, 4'd0, 4'd0, 16'hFFFD));
        run_prog("li");
        want[1] = 32'h0000_0005;
        want[2] = 32'hFFFF_FFFD;
        for (int i = 1; i <= 2; i++) begin
            dbg_raddr = 4'(i);
            #1;
            checks++;
            if (dbg_rdata !== want[i]) begin
                failures++;
                $display("FAIL li_value r%0d: got %h expected %h", i, dbg_rdata, want[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [31:0] want [6];
        prog.push_back(mk(4'h1, 4'd3, 4'd1, 4'd1, 16'h0000));
        prog.push_back(mk(4'h2, 4'd4, 4'd1, 4'd1, 16'h0000));
        prog.push_back(mk(4'h9, 4'd5, 4'd2, 4'd1, 16'h0000));
        run_prog("rtype");
        want[3] = 32'h0000_000A;
        want[4] = 32'h0000_0000;
        want[5] = 32'h07FF_FFFF;
        for (int i = 3; i <= 5; i++) begin
            dbg_raddr = 4'(i);
            #1;
            checks++;
            if (dbg_rdata !== want[i]) begin
                failures++;
                $display("FAIL rtype_value r%0d: got %h expected %h", i, dbg_rdata, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        instr = mk(4'hE, 4'd6, 4'd1, 4'd1, 16'h1234);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        checks++;
        if (illegal !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse: got %b expected 1", illegal);
        end
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL illegal_state: ready=%b done=%b expected 1 0", instr_ready, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_width: got %b expected 0", illegal);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || instr_ready !== 1'b1) begin
                failures++;
                $display("FAIL illegal_quiet: done=%b ready=%b expected 0 1", done, instr_ready);
            end
        end
        for (int i = 0; i < 16; i++) begin
            dbg_raddr = 4'(i);
            #1;
            checks++;
            if (dbg_rdata !== ref_regs[i]) begin
                failures++;
                $display("FAIL illegal_regs r%0d: got %h expected %h", i, dbg_rdata, ref_regs[i]);
            end
        end
    endtask

    task automatic test_r0();
        prog.push_back(mk(4'h1, 4'd0, 4'd1, 4'd1, 16'h0000));
        run_prog("r0");
        checks++;
        if (result !== 32'h0000_000A) begin
            failures++;
            $display("FAIL r0_result: got %h expected 0000000a", result);
        end
    endtask

    task automatic test_back_to_back();
        prog.push_back(mk(4'hA, 4'd6, 4'd1, 4'd0, 16'h0001));
        prog.push_back(mk(4'hA, 4'd7, 4'd6, 4'd0, 16'h0002));
        prog.push_back(mk(4'hA, 4'd8, 4'd7, 4'd0, 16'hFFFF));
        run_prog("back_to_back");
        dbg_raddr = 4'd8;
        #1;
        checks++;
        if (dbg_rdata !== 32'h0000_0007) begin
            failures++;
            $display("FAIL b2b_chain r8: got %h expected 00000007", dbg_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        instr = mk(4'hA, 4'd9, 4'd1, 4'd0, 16'h0007);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_ref();
        #1;
        checks++;
        if (done !== 1'b0 || instr_ready !== 1'b1 || alu_func !== 4'h0) begin
            failures++;
            $display("FAIL midreset_abort: done=%b ready=%b func=%h expected 0 1 0", done, instr_ready, alu_func);
        end
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_done: got %b expected 0", saw_done);
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_idle: ready=%b expected 1", instr_ready);
        end
        dbg_raddr = 4'd9;
        #1;
        checks++;
        if (dbg_rdata !== 32'd0) begin
            failures++;
            $display("FAIL midreset_rd r9: got %h expected 0", dbg_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_li();
        test_rtype();
        test_illegal();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
